// File: rtl/cache_nway.sv
// cache_nway: WAYS-way set-associative, write-back / write-allocate cache.
// CPU side is 32-bit words (mem_*), memory side is 256-bit lines (pmem_*).
// Replacement: fill invalid ways first (lowest index), otherwise tree pseudo-LRU.
// Optional build macro CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module cache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 32 - 5 - IDX;
    localparam int WB   = $clog2(WAYS);
    localparam int PB   = WAYS - 1;

    typedef enum logic [1:0] {
        S_CHECK,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    // Storage arrays
    logic [TAGW-1:0] r_tag   [SETS][WAYS];
    logic [255:0]    r_data  [SETS][WAYS];
    logic [WAYS-1:0] r_valid [SETS];
    logic [WAYS-1:0] r_dirty [SETS];
    logic [PB-1:0]   r_plru  [SETS];

    state_t          r_state;
    state_t          w_state_next;
    logic [WB-1:0]   r_victim;
    logic [TAGW-1:0] r_miss_tag;
    logic [IDX-1:0]  r_miss_idx;

    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic [2:0]      w_word;
    logic            w_req;
    logic [WAYS-1:0] w_hit_vec;
    logic            w_hit;
    logic [WB-1:0]   w_hit_way;
    logic [255:0]    w_hit_line;
    logic [31:0]     w_hit_word;
    logic [255:0]    w_merged;
    logic [WB-1:0]   w_victim_sel;
    logic            w_victim_dirty;
    logic            w_miss_start;
    logic            w_unused;

    assign w_idx    = mem_address[IDX+4:5];
    assign w_tag    = mem_address[31:IDX+5];
    assign w_word   = mem_address[4:2];
    assign w_req    = mem_read | mem_write;
    assign w_unused = ^mem_address[1:0];

    // Walk the PLRU tree from the root, pointing every node on the path away from 'way'.
    function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] bits, input logic [WB-1:0] way);
        logic [PB-1:0] nb;
        logic [WB-1:0] sh;
        int unsigned   node;
        nb   = bits;
        node = 0;
        for (int unsigned lvl = 0; lvl < WB; lvl++) begin
            sh = way >> (WB - 1 - lvl);
            if (sh[0])
                nb = nb & ~(PB'(1) << node);
            else
                nb = nb | (PB'(1) << node);
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return nb;
    endfunction

    // Follow the PLRU bits from the root: 0 = left subtree, 1 = right subtree.
    function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] bits);
        logic [PB-1:0] sh;
        logic [WB-1:0] way;
        int unsigned   node;
        node = 0;
        way  = '0;
        for (int unsigned lvl = 0; lvl < WB; lvl++) begin
            sh   = bits >> node;
            way  = (way << 1) | WB'(sh[0]);
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return way;
    endfunction

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_vec[w] = 1'b1;
                w_hit_way    = WB'(w);
            end
        end
    end

    assign w_hit      = |w_hit_vec;
    assign w_hit_line = r_data[w_idx][w_hit_way];

    // Word select and byte-lane merge on the hit line
    always_comb begin
        w_hit_word = '0;
        w_merged   = w_hit_line;
        for (int unsigned k = 0; k < 8; k++) begin
            if (w_word == 3'(k)) begin
                w_hit_word = w_hit_line[k*32 +: 32];
                for (int unsigned b = 0; b < 4; b++) begin
                    if (mem_byte_enable[b])
                        w_merged[k*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Victim choice: scanning from the top so the lowest invalid way wins, PLRU otherwise
    always_comb begin
        w_victim_sel = plru_victim(r_plru[w_idx]);
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!r_valid[w_idx][WAYS-1-w])
                w_victim_sel = WB'(WAYS - 1 - w);
        end
    end

    assign w_victim_dirty = r_valid[w_idx][w_victim_sel] && r_dirty[w_idx][w_victim_sel];
    assign w_miss_start   = (r_state == S_CHECK) && w_req && !w_hit;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_CHECK;
        else
            r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CHECK:     if (w_req && !w_hit) w_state_next = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (pmem_resp) w_state_next = S_ALLOCATE;
            S_ALLOCATE:  if (pmem_resp) w_state_next = S_CHECK;
            default:     w_state_next = S_CHECK;
        endcase
    end

    // FSM outputs; everything is zero unless the current state drives it
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            S_CHECK: begin
                if (w_req && w_hit) begin
                    mem_resp = 1'b1;
                    if (mem_read)
                        mem_rdata = w_hit_word;
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_miss_idx][r_victim], r_miss_idx, 5'b0};
                pmem_wdata   = r_data[r_miss_idx][r_victim];
            end
            S_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {r_miss_tag, r_miss_idx, 5'b0};
            end
            default: ;
        endcase
    end

    // Capture victim and miss address when leaving CHECK so a dropped request still fills the right line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_victim   <= '0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
        end else if (w_miss_start) begin
            r_victim   <= w_victim_sel;
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
        end
    end

    // Valid, dirty and PLRU state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            case (r_state)
                S_CHECK: begin
                    if (w_req && w_hit) begin
                        r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                        if (mem_write)
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp)
                        r_dirty[r_miss_idx][r_victim] <= 1'b0;
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        r_valid[r_miss_idx][r_victim] <= 1'b1;
                        r_dirty[r_miss_idx][r_victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: write-hit merge and line fill
    always_ff @(posedge clk) begin
        if ((r_state == S_CHECK) && mem_write && w_hit)
            r_data[w_idx][w_hit_way] <= w_merged;
        if ((r_state == S_ALLOCATE) && pmem_resp) begin
            r_data[r_miss_idx][r_victim] <= pmem_rdata;
            r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_post_fill;

    // Saturating per-request counters; the hit that completes a fill belongs to the miss already counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_post_fill  <= 1'b0;
        end else begin
            r_post_fill <= (r_state == S_ALLOCATE) && pmem_resp;
            if ((r_state == S_CHECK) && w_req && !r_post_fill) begin
                if (w_hit) begin
                    if (r_hit_count != '1)
                        r_hit_count <= r_hit_count + 32'd1;
                end else begin
                    if (r_miss_count != '1)
                        r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway (WAYS=4, SETS=8): stimulus queues expected CPU and
// memory-side transactions, monitors pop and compare when the DUT presents them.
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_nway #(.WAYS(4), .SETS(8)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cycle = 0;
    int unsigned resp_cyc = 0;
    int unsigned fill_resp_cyc = 0;
    int unsigned wr_run = 0;
    int unsigned last_wr_hold = 0;
    int          lat = 2;
    bit          spur = 1'b0;

    // Expected CPU responses
    logic [31:0]  q_addr [$];
    logic [31:0]  q_data [$];
    bit           q_chk  [$];
    // Expected memory-side requests
    bit           q_pwr  [$];
    logic [31:0]  q_paddr[$];
    logic [255:0] q_pwd  [$];

    // Physical memory: an unwritten word holds its own byte address
    logic [31:0]  pm [logic [29:0]];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dflt_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k * 4);
        return l;
    endfunction

    task automatic exp_pmem(input bit wr, input logic [31:0] a, input logic [255:0] wd);
        q_pwr.push_back(wr);
        q_paddr.push_back(a);
        q_pwd.push_back(wd);
    endtask

    // Physical memory responder: answers a held request after 'lat' extra cycles
    initial begin
        int          busy;
        logic [29:0] wa;
        busy = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (pmem_read || pmem_write) begin
                if (busy >= lat) begin
                    busy = 0;
                    pmem_resp = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        wa = pmem_address[31:2] + 30'(k);
                        if (pmem_write) pm[wa] = pmem_wdata[k*32 +: 32];
                        else pmem_rdata[k*32 +: 32] = pm.exists(wa) ? pm[wa] : {wa, 2'b00};
                    end
                    if (pmem_read) fill_resp_cyc = cycle;
                end else begin
                    busy++;
                end
            end else begin
                busy = 0;
                if (spur) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = '1;
                end
            end
        end
    end

    // CPU response monitor
    initial begin
        logic [31:0] a, d;
        bit c;
        forever begin
            @(negedge clk);
            if (!rst && mem_resp) begin
                resp_cyc = cycle;
                check("mem_resp_expected", q_addr.size() != 0, 1'b1);
                if (q_addr.size() != 0) begin
                    a = q_addr.pop_front();
                    d = q_data.pop_front();
                    c = q_chk.pop_front();
                    if (c) check($sformatf("rdata@%h", a), mem_rdata, d);
                end
            end
        end
    end

    // Memory-side request monitor
    initial begin
        logic pr, pw;
        bit ewr;
        logic [31:0] ea;
        logic [255:0] ewd;
        pr = 1'b0;
        pw = 1'b0;
        forever begin
            @(negedge clk);
            if (pmem_write) wr_run++;
            else if (wr_run != 0) begin
                last_wr_hold = wr_run;
                wr_run = 0;
            end
            if ((pmem_read && !pr) || (pmem_write && !pw)) begin
                check("pmem_req_expected", q_paddr.size() != 0, 1'b1);
                if (q_paddr.size() != 0) begin
                    ewr = q_pwr.pop_front();
                    ea  = q_paddr.pop_front();
                    ewd = q_pwd.pop_front();
                    check($sformatf("pmem_kind@%h", ea), pmem_write, ewr);
                    check("pmem_addr", pmem_address, ea);
                    if (ewr) check("pmem_wdata", pmem_wdata, ewd);
                end
            end
            pr = pmem_read;
            pw = pmem_write;
        end
    end

    task automatic cpu_op(input logic [31:0] a, input bit we, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp, output int cyc);
        @(posedge clk); #1;
        q_addr.push_back(a);
        q_data.push_back(exp);
        q_chk.push_back(!we);
        mem_address = a;
        mem_read = !we;
        mem_write = we;
        mem_wdata = wd;
        mem_byte_enable = be;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_resp && cyc < 100);
        if (!mem_resp) check($sformatf("timeout@%h", a), mem_resp, 1'b1);
        @(posedge clk); #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int lat_exp);
        int cyc;
        cpu_op(a, 1'b0, '0, 4'b0000, exp, cyc);
        check($sformatf("latency_rd@%h", a), cyc, lat_exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int lat_exp);
        int cyc;
        cpu_op(a, 1'b1, d, be, '0, cyc);
        check($sformatf("latency_wr@%h", a), cyc, lat_exp);
    endtask

    initial begin
        logic [255:0] wb_line;
        rst = 1'b1;
        mem_address = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        mem_byte_enable = '0;
        pm[30'h11] = 32'hDEAD_BEEF;   // word1 of the line at 0x40
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 256'h0);
        rst = 1'b0;

        // Clean miss then hits in set 2
        exp_pmem(1'b0, 32'h40, '0);
        rd(32'h40, 32'h40, 5);
        wr(32'h44, 32'h1234_5678, 4'b0011, 1);
        rd(32'h44, 32'hDEAD_5678, 1);

        // Fill the remaining three ways of set 2 (ways 1,2,3 accessed after way 0)
        for (int t = 1; t <= 3; t++) begin
            exp_pmem(1'b0, (32'(t) << 8) | 32'h40, '0);
            rd((32'(t) << 8) | 32'h40, (32'(t) << 8) | 32'h40, 5);
        end

        // Fifth tag evicts dirty way 0: write-back at 0x40, then fill
        wb_line = dflt_line(32'h40);
        wb_line[63:32] = 32'hDEAD_5678;
        exp_pmem(1'b1, 32'h40, wb_line);
        exp_pmem(1'b0, 32'h440, '0);
        rd(32'h440, 32'h440, 8);
        check("wb_hold_cycles", last_wr_hold, 3);
        check("resp_after_fill", resp_cyc - fill_resp_cyc, 1);
        rd(32'h140, 32'h140, 1);
        rd(32'h340, 32'h340, 1);
        // Evicted line comes back from memory with the written-back data
        exp_pmem(1'b0, 32'h40, '0);
        rd(32'h44, 32'hDEAD_5678, 5);

        // Reset during ALLOCATE
        exp_pmem(1'b0, 32'h540, '0);
        @(posedge clk); #1;
        mem_address = 32'h540;
        mem_read = 1'b1;
        @(posedge clk); #1;
        check("alloc_pmem_read", pmem_read, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_alloc_pmem_read", pmem_read, 1'b0);
        check("rst_alloc_pmem_write", pmem_write, 1'b0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pmem(1'b0, 32'h540, '0);
        rd(32'h540, 32'h540, 5);
        exp_pmem(1'b0, 32'h40, '0);
        rd(32'h44, 32'hDEAD_5678, 5);

        // Stray pmem_resp while idle changes nothing
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        rd(32'h540, 32'h540, 1);
        rd(32'h44, 32'hDEAD_5678, 1);

        // Request dropped mid-miss: fill completes, no response, later hit
        exp_pmem(1'b0, 32'h640, '0);
        @(posedge clk); #1;
        mem_address = 32'h640;
        mem_read = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b0;
        repeat (6) @(posedge clk);
        rd(32'h640, 32'h640, 1);

        // Write miss allocates, then reads back merged word
        exp_pmem(1'b0, 32'h740, '0);
        wr(32'h748, 32'hCAFE_F00D, 4'b1111, 5);
        rd(32'h748, 32'hCAFE_F00D, 1);
        rd(32'h74C, 32'h74C, 1);

`ifdef CACHE_STATS_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pmem(1'b0, 32'h800, '0);
        rd(32'h800, 32'h800, 5);
        rd(32'h800, 32'h800, 1);
        rd(32'h804, 32'h804, 1);
        exp_pmem(1'b0, 32'hA00, '0);
        rd(32'hA00, 32'hA00, 5);
        rd(32'hA00, 32'hA00, 1);
        check("hit_count", hit_count, 32'd3);
        check("miss_count", miss_count, 32'd2);
        force dut.r_hit_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_hit_count;
        rd(32'h804, 32'h804, 1);
        check("hit_count_sat", hit_count, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        check("mem_queue_drained", q_addr.size(), 0);
        check("pmem_queue_drained", q_paddr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
